timer_irq_source: RTL and testbench

- Memory-mapped count-down timer on the MIPS microsystem bridge.
- Raises a hardware interrupt line that feeds one bit of the CPU's HWInt[5:0] vector.
- Acts as the device-side initiator of the interrupt handshake that the coprocessor receives.
- Two instances plus an external interrupt pin drive HWInt[2:0].

---
 rtl/timer_irq_source.sv | 134 +++++++++++++
 tb/tb_timer_irq_source.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// Memory-mapped count-down timer for the bridge; drives one HWInt bit.
// CTRL/PRESET are written over the bus, COUNT runs through IDLE/LOAD/CNT/INT.
module timer_irq_source #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam int unsigned DW = 32;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_en;
    logic [1:0]      r_mode;
    logic            r_im;
    logic [DW-1:0]   r_preset;
    logic [DW-1:0]   r_count;
    logic            r_irq_flag;
    logic            r_pulse_clr;

    logic [1:0]      w_sel;
    logic            w_wr_ctrl;
    logic            w_wr_preset;
    logic [DW-1:0]   w_load_val;
    logic            w_unused_addr;

    assign w_sel         = Addr[1:0];
    assign w_wr_ctrl     = WE && (w_sel == SEL_CTRL);
    assign w_wr_preset   = WE && (w_sel == SEL_PRESET);
    assign w_unused_addr = ^Addr[29:2];

    // A PRESET write sharing the edge with LOAD is the value that gets loaded.
    assign w_load_val = w_wr_preset ? Din : r_preset;

    // Timer FSM and bus register file; bus writes are applied last so they win.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_en        <= 1'b0;
            r_mode      <= 2'b00;
            r_im        <= 1'b0;
            r_preset    <= PRESET_RST;
            r_count     <= '0;
            r_irq_flag  <= 1'b0;
            r_pulse_clr <= 1'b0;
        end else begin
            r_pulse_clr <= 1'b0;
            if (r_pulse_clr) begin
                r_irq_flag <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!r_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= w_load_val;
                        r_state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (!r_en) begin
                        r_state <= S_IDLE;
                    end else if (r_count > DW'(1)) begin
                        r_count <= r_count - DW'(1);
                    end else begin
                        // Reaching 1 or starting at 0 both fire; never wraps below 0.
                        r_count <= '0;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    r_irq_flag <= 1'b1;
                    if (r_mode == MODE_RELOAD) begin
                        r_pulse_clr <= 1'b1;
                        r_state     <= S_LOAD;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_wr_ctrl) begin
                r_en       <= Din[0];
                r_mode     <= Din[2:1];
                r_im       <= Din[3];
                r_irq_flag <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= Din;
            end
        end
    end

    // Read mux; unmapped address and upper CTRL bits read as zero.
    always_comb begin
        Dout = '0;
        case (w_sel)
            SEL_CTRL:   Dout = {28'd0, r_im, r_mode, r_en};
            SEL_PRESET: Dout = r_preset;
            SEL_COUNT:  Dout = r_count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = r_im & r_irq_flag;

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: vector table, directed corner sequences,
// then random bus traffic against a cycle-level reference model.
module tb_timer_irq_source;

    localparam logic [31:0] PRESET_RST = 32'h0000_0000;
    localparam int ST_IDLE = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_CNT  = 2;
    localparam int ST_INT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    timer_irq_source #(.PRESET_RST(PRESET_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_st;
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_pulse_left;

    typedef struct {
        logic        rst;
        logic        we;
        logic [29:0] wa;
        logic [31:0] wd;
        logic [29:0] ra;
        logic [31:0] ed;
        logic        ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int rst, input int we, input int wa,
                               input logic [31:0] wd, input int ra,
                               input logic [31:0] ed, input int ei);
        vec_t r;
        r.rst = 1'(rst);
        r.we  = 1'(we);
        r.wa  = 30'(wa);
        r.wd  = wd;
        r.ra  = 30'(ra);
        r.ed  = ed;
        r.ei  = 1'(ei);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic we, input logic [29:0] a,
                              input logic [31:0] d);
        logic wc;
        logic wp;
        if (rst) begin
            m_st = ST_IDLE; m_en = 1'b0; m_mode = 2'b00; m_im = 1'b0;
            m_preset = PRESET_RST; m_count = 32'd0; m_flag = 1'b0; m_pulse_left = 0;
            return;
        end
        wc = we && (a[1:0] == 2'd0);
        wp = we && (a[1:0] == 2'd1);
        if (m_pulse_left > 0) begin
            m_pulse_left--;
            if (m_pulse_left == 0) m_flag = 1'b0;
        end
        case (m_st)
            ST_IDLE: if (m_en) m_st = ST_LOAD;
            ST_LOAD: begin
                if (!m_en) m_st = ST_IDLE;
                else begin
                    m_count = wp ? d : m_preset;
                    m_st = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!m_en) m_st = ST_IDLE;
                else if (m_count <= 32'd1) begin
                    m_count = 32'd0;
                    m_st = ST_INT;
                end else m_count = m_count - 32'd1;
            end
            default: begin
                m_flag = 1'b1;
                if (m_mode == 2'b01) begin
                    m_pulse_left = 1;
                    m_st = ST_LOAD;
                end else begin
                    m_en = 1'b0;
                    m_st = ST_IDLE;
                end
            end
        endcase
        if (wc) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 1'b0;
        end
        if (wp) m_preset = d;
    endtask

    function automatic logic [31:0] model_dout(input logic [29:0] ra);
        case (ra[1:0])
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive inputs, take the edge, settle to the negedge.
    task automatic tick(input int rst, input int we, input int a, input logic [31:0] d);
        reset = 1'(rst);
        WE    = 1'(we);
        Addr  = 30'(a);
        Din   = d;
        @(posedge clk);
        model_step(1'(rst), 1'(we), 30'(a), d);
        #1;
        WE    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string name, input int ra, input logic [31:0] exp);
        Addr = 30'(ra);
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        chk(name, 32'(IRQ), 32'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 32'd0);
    endtask

    initial begin
        logic [29:0] ra;
        logic [31:0] d;
        int          rst_r;
        int          we_r;

        // Reset read-back, MODE0 latency with PRESET=5, address decode
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 2, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 1, 5, 1, 5, 0));
        tbl.push_back(v(0, 1, 0, 9, 0, 9, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 5, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 4, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 3, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 8, 1));
        tbl.push_back(v(0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 7, 2, 0, 0));
        tbl.push_back(v(0, 1, 3, 32'hFFFF_FFFF, 3, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'hFFFF_FFF8, 0, 8, 0));
        tbl.push_back(v(0, 1, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0));
        tbl.push_back(v(0, 0, 0, 0, 32'h3FFF_FFF5, 32'hDEAD_BEEF, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 8, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            tick(int'(tbl[i].rst), int'(tbl[i].we), int'(tbl[i].wa), tbl[i].wd);
            rd($sformatf("vec%0d_dout", i), int'(tbl[i].ra), tbl[i].ed);
            irq_chk($sformatf("vec%0d_irq", i), tbl[i].ei);
        end

        // MODE1 auto-reload, PRESET=3: pulses after E6 then every 5 cycles
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd3);
        tick(0, 1, 0, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            tick(0, 0, 0, 0);
            irq_chk($sformatf("mode1_E%0d", k), (k >= 6) && ((k - 6) % 5 == 0));
        end
        tick(0, 1, 0, 0);
        idle(4);

        // IM=0: flag sets silently; setting IM via CTRL also clears the flag
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd2);
        tick(0, 1, 0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, 0, 0);
            irq_chk($sformatf("im0_E%0d", k), 1'b0);
        end
        rd("im0_ctrl_en_cleared", 0, 32'd0);
        tick(0, 1, 0, 32'h8);
        irq_chk("im_set_clears_flag", 1'b0);
        rd("im_set_ctrl", 0, 32'h8);
        idle(2);
        irq_chk("im_set_stays_low", 1'b0);

        // Pause at COUNT=2, COUNT write ignored, re-enable reloads, PRESET=0
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd6);
        tick(0, 1, 0, 32'h9);
        idle(5);
        tick(0, 1, 0, 32'h8);
        rd("pause_count", 2, 32'd2);
        idle(4);
        rd("pause_hold", 2, 32'd2);
        irq_chk("pause_no_irq", 1'b0);
        tick(0, 1, 2, 32'd7);
        rd("count_write_ignored", 2, 32'd2);
        tick(0, 1, 0, 32'h9);
        tick(0, 0, 0, 0);
        rd("reen_load_cycle", 2, 32'd2);
        tick(0, 0, 0, 0);
        rd("reen_reload", 2, 32'd6);
        tick(0, 1, 0, 0);
        idle(1);
        tick(0, 1, 1, 32'd0);
        tick(0, 1, 0, 32'h9);
        idle(2);
        rd("preset0_count", 2, 32'd0);
        irq_chk("preset0_E2", 1'b0);
        idle(1);
        irq_chk("preset0_E3", 1'b0);
        idle(1);
        irq_chk("preset0_E4", 1'b1);
        rd("preset0_ctrl", 0, 32'h8);
        tick(0, 1, 0, 0);

        // Reset at COUNT=1 in MODE1
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd3);
        tick(0, 1, 0, 32'hB);
        idle(4);
        rd("pre_reset_count", 2, 32'd1);
        tick(1, 0, 0, 0);
        irq_chk("reset_irq", 1'b0);
        for (int a = 0; a < 4; a++) rd($sformatf("reset_reg%0d", a), a, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, 0);
            irq_chk($sformatf("post_reset_%0d", k), 1'b0);
        end

        // CTRL write coinciding with INT: bus wins, FSM follows old MODE0
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd1);
        tick(0, 1, 0, 32'h9);
        idle(2);
        rd("coll_count", 2, 32'd1);
        idle(1);
        irq_chk("coll_int_cycle", 1'b0);
        tick(0, 1, 0, 32'hB);
        rd("coll_ctrl_wins", 0, 32'hB);
        irq_chk("coll_flag_cleared", 1'b0);
        idle(1);
        irq_chk("coll_E5", 1'b0);
        idle(1);
        rd("coll_reload", 2, 32'd1);
        idle(1);
        irq_chk("coll_E7", 1'b0);
        idle(1);
        irq_chk("coll_E8", 1'b1);
        idle(1);
        irq_chk("coll_E9", 1'b0);
        tick(0, 1, 0, 0);
        idle(3);

        // PRESET write during LOAD is the value loaded
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 32'd4);
        tick(0, 1, 0, 32'h9);
        idle(1);
        tick(0, 1, 1, 32'd2);
        rd("load_new_preset", 2, 32'd2);
        idle(2);
        irq_chk("load_E4", 1'b0);
        idle(1);
        irq_chk("load_E5", 1'b1);
        tick(0, 1, 0, 0);

        // Random bus traffic against the reference model
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(199) == 0) ? 1 : 0;
            we_r  = ($urandom_range(4) == 0) ? 1 : 0;
            ra    = 30'($urandom);
            d     = $urandom;
            if (ra[1:0] == 2'd1) d = 32'($urandom_range(6));
            if (ra[1:0] == 2'd0 && $urandom_range(2) != 0) d[0] = 1'b1;
            tick(rst_r, we_r, int'(ra), d);
            ra = 30'($urandom);
            rd("rand_dout", int'(ra), model_dout(ra));
            irq_chk("rand_irq", m_im & m_flag);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
